// File: rtl/cache_mem_pkg.sv
// Shared types, derived-width helpers and address-field extractors for the
// direct-mapped write-back data cache.
package cache_mem_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int off_width(input int words);
    return $clog2(words);
  endfunction

  function automatic int tag_width(input int addr_w, input int lines, input int words);
    return addr_w - $clog2(lines) - $clog2(words) - BYTE_OFF_W;
  endfunction

  // Extractors work on a zero-extended 64-bit address; callers size-cast the result.
  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int idx_w,
                                           input int off_w);
    return addr >> (idx_w + off_w + BYTE_OFF_W);
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int idx_w,
                                             input int off_w);
    return (addr >> (off_w + BYTE_OFF_W)) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_word(input logic [63:0] addr, input int off_w);
    return (addr >> BYTE_OFF_W) & ((64'd1 << off_w) - 64'd1);
  endfunction

endpackage

// File: rtl/cache_array.sv
// Tag/valid/dirty/data storage: combinational read, word/byte write port,
// line fill port and dirty-clear port.
module cache_array
  import cache_mem_pkg::*;
#(
  parameter  int LINES  = 4,
  parameter  int WORDS  = 4,
  parameter  int TAG_W  = 26,
  localparam int IDX_W  = idx_width(LINES),
  localparam int OFF_W  = off_width(WORDS),
  localparam int LINE_W = WORD_W * WORDS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_word,
  input  logic [3:0]        wr_be,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              clean_en,
  input  logic [IDX_W-1:0]  clean_idx
);

  logic [LINE_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;

  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];

  // NOTE: data and tag arrays have no reset branch; valid/dirty alone decide
  // whether a line means anything, so the wide arrays stay plain RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (fill_en) begin
        data_mem[fill_idx] <= fill_line;
        tag_mem[fill_idx]  <= fill_tag;
      end else if (wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_be[b])
            data_mem[wr_idx][int'(wr_word)*WORD_W + b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (clean_en) dirty_q[clean_idx] <= 1'b0;
      if (wr_en)    dirty_q[wr_idx]    <= 1'b1;
      if (fill_en) begin
        valid_q[fill_idx] <= 1'b1;
        dirty_q[fill_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller: hit logic,
// miss-handling FSM, line-wide memory handshake and saturating counters.
module cache_mem_ctrl
  import cache_mem_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int LINES  = 4,
  parameter  int WORDS  = 4,
  parameter  int CNT_W  = 16,
  localparam int IDX_W  = idx_width(LINES),
  localparam int OFF_W  = off_width(WORDS),
  localparam int TAG_W  = tag_width(ADDR_W, LINES, WORDS),
  localparam int LINE_W = WORD_W * WORDS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic              byte_access,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam logic [OFF_W+1:0] LINE_OFF = '0;

  state_t            state;
  logic [TAG_W-1:0]  tag, miss_tag, rd_tag;
  logic [IDX_W-1:0]  idx, miss_idx, arr_idx;
  logic [OFF_W-1:0]  word_sel;
  logic              rd_valid, rd_dirty, hit, victim_dirty;
  logic [LINE_W-1:0] rd_line;
  logic [31:0]       hit_word, hit_rdata, rdata_q, wr_data;
  logic [7:0]        hit_byte;
  logic [3:0]        wr_be;
  logic              wr_hit, fill_done, clean_done;

  assign tag      = TAG_W'(addr_tag(64'(addr), IDX_W, OFF_W));
  assign idx      = IDX_W'(addr_index(64'(addr), IDX_W, OFF_W));
  assign word_sel = OFF_W'(addr_word(64'(addr), OFF_W));

  // While a miss is in flight the array is addressed by the captured index,
  // so a misbehaving CPU changing addr cannot corrupt the transfer.
  assign arr_idx = (state == IDLE) ? idx : miss_idx;

  assign hit          = rd_valid && (rd_tag == tag);
  assign victim_dirty = rd_valid && rd_dirty;
  assign ready        = (state == IDLE) && req && hit;

  assign hit_word  = rd_line[int'(word_sel)*WORD_W +: WORD_W];
  assign hit_byte  = 8'(hit_word >> {addr[1:0], 3'b000});
  assign hit_rdata = byte_access ? {24'd0, hit_byte} : hit_word;
  assign rdata     = (ready && !we) ? hit_rdata : rdata_q;

  assign wr_be   = byte_access ? (4'b0001 << addr[1:0]) : 4'hF;
  assign wr_data = byte_access ? {4{wdata[7:0]}} : wdata;
  assign wr_hit  = ready && we;

  assign fill_done  = (state == FILL) && mem_ready;
  assign clean_done = (state == WRITEBACK) && mem_ready;
  assign mem_wdata  = rd_line;

  cache_array #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TAG_W (TAG_W)
  ) u_array (
    .clock     (clock),
    .reset     (reset),
    .rd_idx    (arr_idx),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_line   (rd_line),
    .wr_en     (wr_hit),
    .wr_idx    (idx),
    .wr_word   (word_sel),
    .wr_be     (wr_be),
    .wr_data   (wr_data),
    .fill_en   (fill_done),
    .fill_idx  (miss_idx),
    .fill_tag  (miss_tag),
    .fill_line (mem_rdata),
    .clean_en  (clean_done),
    .clean_idx (miss_idx)
  );

  // NOTE: every register below uses non-blocking assignment so all state
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      rdata_q    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            if (!we) rdata_q <= hit_rdata;
          end else if (req) begin
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            mem_req <= 1'b1;
            mem_we  <= victim_dirty;
            state   <= victim_dirty ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            mem_we <= 1'b0;
            state  <= FILL;
          end
        end
        FILL: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Miss bookkeeping is only meaningful while mem_req is high, so it needs no reset.
  always_ff @(posedge clock) begin
    if (state == IDLE && req && !hit) begin
      miss_idx <= idx;
      miss_tag <= tag;
      mem_addr <= victim_dirty ? {rd_tag, idx, LINE_OFF} : {tag, idx, LINE_OFF};
    end else if (clean_done) begin
      mem_addr <= {miss_tag, miss_idx, LINE_OFF};
    end
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Scoreboard bench for cache_mem_ctrl: a reference cache/memory model predicts
// latency, read data, memory transactions and counter values.
module tb_cache_mem_ctrl;

  localparam int LINES   = 4;
  localparam int WORDS   = 4;
  localparam int CNT_W   = 4;
  localparam int LINE_W  = 32 * WORDS;
  localparam int OFFB    = 2 + $clog2(WORDS);
  localparam int IDXB    = $clog2(LINES);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic              we;
    logic [31:0]       addr;
    logic [LINE_W-1:0] data;
  } mem_txn_t;

  logic              clock, reset, req, we, byte_access, ready;
  logic [31:0]       addr, wdata, rdata, mem_addr;
  logic              mem_req, mem_we, mem_ready;
  logic [LINE_W-1:0] mem_wdata, mem_rdata;
  logic [CNT_W-1:0]  hit_count, miss_count;

  cache_mem_ctrl #(.CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .byte_access (byte_access),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .ready       (ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference state
  logic [LINE_W-1:0] bk_mem  [logic [31:0]];
  logic [LINE_W-1:0] ref_mem [logic [31:0]];
  logic              m_valid [LINES];
  logic              m_dirty [LINES];
  logic [31:0]       m_tag   [LINES];
  int                exp_hits, exp_misses, mem_delay;
  mem_txn_t          exp_mem [$];
  logic [31:0]       rd_q [$];
  logic [31:0]       last_rd;

  function automatic logic [LINE_W-1:0] default_line(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    for (int w = 0; w < WORDS; w++) l[w*32 +: 32] = {8'hC0, a[15:0], 8'(w)};
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] bk_line(input logic [31:0] a);
    if (bk_mem.exists(a)) return bk_mem[a];
    return default_line(a);
  endfunction

  function automatic logic [LINE_W-1:0] ref_line(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return default_line(a);
  endfunction

  // Reset drops dirty lines, so architectural memory becomes the backing memory.
  task automatic clear_model();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    exp_hits   = 0;
    exp_misses = 0;
    exp_mem.delete();
    rd_q.delete();
    ref_mem = bk_mem;
  endtask

  task automatic predict(input logic w, input logic b, input logic [31:0] a,
                         input logic [31:0] d, output int lat);
    int idx, wsel, bsel;
    logic [31:0] tg, la, va;
    logic [LINE_W-1:0] line;
    mem_txn_t t;
    idx  = int'((a >> OFFB) % LINES);
    wsel = int'((a >> 2) % WORDS);
    bsel = int'(a % 4);
    tg   = a >> (OFFB + IDXB);
    la   = a & ~((32'd1 << OFFB) - 32'd1);
    if (m_valid[idx] && m_tag[idx] == tg) begin
      lat = 0;
    end else begin
      if (exp_misses < CNT_MAX) exp_misses++;
      lat = 2 + mem_delay;
      if (m_valid[idx] && m_dirty[idx]) begin
        va = (m_tag[idx] << (OFFB + IDXB)) | (32'(idx) << OFFB);
        t.we = 1'b1; t.addr = va; t.data = ref_line(va);
        exp_mem.push_back(t);
        lat += mem_delay + 1;
      end
      t.we = 1'b0; t.addr = la; t.data = '0;
      exp_mem.push_back(t);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    if (exp_hits < CNT_MAX) exp_hits++;
    line = ref_line(la);
    if (w) begin
      if (b) line[wsel*32 + bsel*8 +: 8] = d[7:0];
      else   line[wsel*32 +: 32] = d;
      ref_mem[la]  = line;
      m_dirty[idx] = 1'b1;
    end else if (b) begin
      rd_q.push_back({24'd0, line[wsel*32 + bsel*8 +: 8]});
    end else begin
      rd_q.push_back(line[wsel*32 +: 32]);
    end
  endtask

  // Backing memory: grants after mem_delay waiting cycles, checking each cycle
  // of the request against the predicted transaction.
  initial begin
    int busy;
    mem_txn_t t;
    busy      = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      mem_ready = 1'b0;
      if (!reset || !mem_req) begin
        busy = 0;
      end else if (exp_mem.size() == 0) begin
        check("unexpected_mem_req", mem_req, 1'b0);
        mem_ready = 1'b1;
        mem_rdata = bk_line(mem_addr);
      end else begin
        t = exp_mem[0];
        check("mem_we", mem_we, t.we);
        check("mem_addr", mem_addr, t.addr);
        if (busy < mem_delay) begin
          busy++;
        end else begin
          busy = 0;
          void'(exp_mem.pop_front());
          mem_ready = 1'b1;
          if (t.we) begin
            check("mem_wdata", mem_wdata, t.data);
            bk_mem[t.addr] = t.data;
          end else begin
            mem_rdata = bk_line(mem_addr);
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0; req = 1'b0; we = 1'b0; byte_access = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    clear_model();
  endtask

  // Called at posedge+1; returns at posedge+1 after the completing edge.
  task automatic access(input logic w, input logic b, input logic [31:0] a,
                        input logic [31:0] d);
    int lat, cyc;
    bit done;
    logic [31:0] exp_rd;
    predict(w, b, a, d, lat);
    req = 1'b1; we = w; byte_access = b; addr = a; wdata = d;
    cyc = 0;
    done = 0;
    while (!done && cyc < 200) begin
      @(negedge clock);
      if (ready) begin
        done = 1;
        check("latency", cyc, lat);
        if (!w) begin
          exp_rd  = rd_q.pop_front();
          check("rdata", rdata, exp_rd);
          last_rd = exp_rd;
        end
      end else begin
        cyc++;
      end
      @(posedge clock);
      #1;
    end
    if (!done) check("ready_timeout", 1'b0, 1'b1);
    req = 1'b0;
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_misses);
    check("mem_pending", exp_mem.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [31:0] a;
    mem_delay = 0;
    last_rd   = '0;
    bk_mem[32'h40]  = {32'hAAAA_000D, 32'hAAAA_000C, 32'hAAAA_000B, 32'hAAAA_0001};
    bk_mem[32'h140] = {32'hBBBB_000D, 32'hBBBB_000C, 32'hBBBB_000B, 32'hBBBB_0001};
    do_reset();

    check("rst_ready", ready, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);

    // Cold miss, then byte write hit and read-back hits
    access(1'b0, 1'b0, 32'h40, 32'h0);
    access(1'b1, 1'b1, 32'h41, 32'h0000_0055);
    access(1'b0, 1'b0, 32'h40, 32'h0);
    check("merged_word", last_rd, 32'hAAAA_5501);
    access(1'b0, 1'b1, 32'h41, 32'h0);

    // Conflict on a dirty line: writeback of 0x40 then fill of 0x140
    access(1'b0, 1'b0, 32'h140, 32'h0);
    check("conflict_word", last_rd, 32'hBBBB_0001);
    @(negedge clock);
    check("rdata_hold", rdata, last_rd);
    check("idle_ready", ready, 1'b0);
    @(posedge clock);
    #1;

    // Slow memory
    mem_delay = 5;
    access(1'b0, 1'b0, 32'h90, 32'h0);

    // Reset in the middle of a fill
    predict(1'b0, 1'b0, 32'h2A0, 32'h0, lat);
    req = 1'b1; we = 1'b0; byte_access = 1'b0; addr = 32'h2A0;
    repeat (3) @(posedge clock);
    #1;
    check("midfill_mem_req", mem_req, 1'b1);
    check("midfill_mem_we", mem_we, 1'b0);
    reset = 1'b0;
    req   = 1'b0;
    @(posedge clock);
    #1;
    check("abandon_mem_req", mem_req, 1'b0);
    check("abandon_hits", hit_count, 0);
    check("abandon_misses", miss_count, 0);
    check("abandon_ready", ready, 1'b0);
    reset = 1'b1;
    clear_model();
    access(1'b0, 1'b0, 32'h2A0, 32'h0);
    check("remiss_count", miss_count, 1);

    // Saturation of the 4-bit hit counter
    mem_delay = 0;
    repeat (20) access(1'b0, 1'b0, 32'h2A0, 32'h0);
    check("hit_saturated", hit_count, 15);

    // Mixed traffic over a few conflicting tags
    for (int i = 0; i < 24; i++) begin
      mem_delay = $urandom_range(0, 2);
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
        | 32'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
